quant_seq_ctrl: RTL

Sequencer for the VSQ quantize stage. It accepts post-ReLU 16x40-bit vectors from the upstream datapath with a valid/ready handshake and writes each tile of DEPTH vectors into the VSQ buffer. It feeds the same vectors to the quantizer's running-max input, issues the quantizer start pulse, and stalls upstream while the quantizer drains the tile to output RAM. It repeats for a programmed number of tiles, then reports done.

---
 rtl/quant_seq_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/quant_seq_ctrl.sv
// VSQ quantize-stage sequencer: fills the VSQ buffer one tile at a time,
// kicks the quantizer, and holds upstream off while the tile drains.
//
// Ports:
//   i_clk, i_rst_n         clock, async active-low reset
//   i_cmd_start/abort      job start pulse, synchronous abort pulse
//   i_cfg_ntile            tiles per job (0 behaves as 1)
//   o_busy, o_done         job active, one-cycle completion pulse
//   o_tile_idx             current tile index
//   i_in_valid/o_in_ready  upstream handshake, i_in_data vector
//   o_buf_we/waddr/wdata   VSQ buffer write port
//   o_q_data, o_q_start    quantizer running-max input and start pulse
//   i_q_ram_we             quantizer output-RAM strobe (drain progress)
module quant_seq_ctrl #(
    parameter int VEC_W = 640,
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int TW    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cmd_start,
    input  logic             i_cmd_abort,
    input  logic [TW-1:0]    i_cfg_ntile,
    output logic             o_busy,
    output logic             o_done,
    output logic [TW-1:0]    o_tile_idx,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [VEC_W-1:0] i_in_data,
    output logic             o_buf_we,
    output logic [AW-1:0]    o_buf_waddr,
    output logic [VEC_W-1:0] o_buf_wdata,
    output logic [VEC_W-1:0] o_q_data,
    output logic             o_q_start,
    input  logic             i_q_ram_we
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_KICK,
        S_DRAIN
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        state, state_nx;
    logic [AW-1:0] wcnt, wcnt_nx;
    logic [AW-1:0] qcnt, qcnt_nx;
    logic [TW-1:0] tile_idx, tile_nx;
    // Stores ntile-1 so the last-tile test is a plain compare.
    logic [TW-1:0] nlast, nlast_nx;
    logic          done_q, done_nx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            wcnt     <= '0;
            qcnt     <= '0;
            tile_idx <= '0;
            nlast    <= '0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            wcnt     <= wcnt_nx;
            qcnt     <= qcnt_nx;
            tile_idx <= tile_nx;
            nlast    <= nlast_nx;
            done_q   <= done_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        wcnt_nx    = wcnt;
        qcnt_nx    = qcnt;
        tile_nx    = tile_idx;
        nlast_nx   = nlast;
        done_nx    = 1'b0;
        o_in_ready = 1'b0;
        o_buf_we   = 1'b0;
        o_q_data   = '0;
        o_q_start  = 1'b0;
        if (i_cmd_abort) begin
            // Abort outranks everything; in IDLE it just swallows a start.
            if (state != S_IDLE) begin
                state_nx = S_IDLE;
                wcnt_nx  = '0;
                qcnt_nx  = '0;
                tile_nx  = '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_cmd_start) begin
                        state_nx = S_FILL;
                        wcnt_nx  = '0;
                        qcnt_nx  = '0;
                        tile_nx  = '0;
                        nlast_nx = (i_cfg_ntile == '0) ? '0
                                 : i_cfg_ntile - 1'b1;
                    end
                end
                S_FILL: begin
                    o_in_ready = 1'b1;
                    if (i_in_valid) begin
                        o_buf_we = 1'b1;
                        o_q_data = i_in_data;
                        wcnt_nx  = wcnt + 1'b1;
                        if (wcnt == LAST) state_nx = S_KICK;
                    end
                end
                S_KICK: begin
                    o_q_start = 1'b1;
                    state_nx  = S_DRAIN;
                end
                S_DRAIN: begin
                    if (i_q_ram_we) begin
                        qcnt_nx = qcnt + 1'b1;
                        if (qcnt == LAST) begin
                            if (tile_idx == nlast) begin
                                done_nx  = 1'b1;
                                state_nx = S_IDLE;
                            end else begin
                                tile_nx  = tile_idx + 1'b1;
                                state_nx = S_FILL;
                            end
                        end
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    assign o_busy      = (state != S_IDLE);
    assign o_done      = done_q;
    assign o_tile_idx  = tile_idx;
    assign o_buf_waddr = wcnt;
    assign o_buf_wdata = i_in_data;

endmodule
